// File: rtl/xregf_arb.sv
// Round-robin arbiter sharing the xregf internal port between controller (C) and host (H).
// Define XREGF_ARB_STATS_EN to add the stat_conflicts counter and its stat_clr input.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef REGF_ADDR_W
`define REGF_ADDR_W 4
`endif

module xregf_arb #(
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    c_req,
    input  logic                    c_we,
    input  logic [`REGF_ADDR_W-1:0] c_addr,
    input  logic [`DATA_W-1:0]      c_wdata,
    output logic                    c_gnt,
    output logic                    c_rvalid,
    output logic [`DATA_W-1:0]      c_rdata,
    input  logic                    h_req,
    input  logic                    h_we,
    input  logic [`REGF_ADDR_W-1:0] h_addr,
    input  logic [`DATA_W-1:0]      h_wdata,
    output logic                    h_gnt,
    output logic                    h_rvalid,
    output logic [`DATA_W-1:0]      h_rdata,
    output logic                    m_sel,
    output logic                    m_we,
    output logic [`REGF_ADDR_W-1:0] m_addr,
    output logic [`DATA_W-1:0]      m_wdata,
    input  logic [`DATA_W-1:0]      m_rdata
`ifdef XREGF_ARB_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [`DATA_W-1:0]      stat_conflicts
`endif
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
    localparam logic [CW-1:0] ONE  = CW'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_C = 2'd1;
    localparam logic [1:0] OWN_H = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [1:0]         tag_q, tag_d;
    logic [`DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic [`DATA_W-1:0] h_rdata_q, h_rdata_d;
    logic               win_c, win_h;

    // last_q: 1 = host owned the port last, so controller wins the next tie
    always_comb begin
        win_c = 1'b0;
        win_h = 1'b0;
        case (state_q)
            OWN_C: begin
                if (c_req && (cnt_q < MAXC || !h_req)) win_c = 1'b1;
                else if (h_req)                        win_h = 1'b1;
            end
            OWN_H: begin
                if (h_req && (cnt_q < MAXC || !c_req)) win_h = 1'b1;
                else if (c_req)                        win_c = 1'b1;
            end
            default: begin
                if (c_req && h_req) begin
                    win_c = last_q;
                    win_h = !last_q;
                end else begin
                    win_c = c_req;
                    win_h = h_req;
                end
            end
        endcase
    end

    assign c_gnt = win_c & !rst;
    assign h_gnt = win_h & !rst;
    assign m_sel = c_gnt | h_gnt;

    always_comb begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (h_gnt) begin
            m_we    = h_we;
            m_addr  = h_addr;
            m_wdata = h_wdata;
        end
    end

    always_comb begin
        state_d = IDLE;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (win_c) begin
            state_d = OWN_C;
            last_d  = 1'b0;
            if (state_q != OWN_C) cnt_d = ONE;
            else if (cnt_q != MAXC) cnt_d = cnt_q + 1'b1;
        end else if (win_h) begin
            state_d = OWN_H;
            last_d  = 1'b1;
            if (state_q != OWN_H) cnt_d = ONE;
            else if (cnt_q != MAXC) cnt_d = cnt_q + 1'b1;
        end
    end

    // Read data arrives one cycle after the grant; pass it through, then hold it
    always_comb begin
        tag_d     = {h_gnt & !h_we, c_gnt & !c_we};
        c_rdata_d = tag_q[0] ? m_rdata : c_rdata_q;
        h_rdata_d = tag_q[1] ? m_rdata : h_rdata_q;
    end

    assign c_rvalid = tag_q[0];
    assign h_rvalid = tag_q[1];
    assign c_rdata  = c_rdata_d;
    assign h_rdata  = h_rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            tag_q     <= '0;
            c_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            tag_q     <= tag_d;
            c_rdata_q <= c_rdata_d;
            h_rdata_q <= h_rdata_d;
        end
    end

`ifdef XREGF_ARB_STATS_EN
    logic [`DATA_W-1:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (stat_clr)
            stat_d = '0;
        else if (c_req && h_req && m_sel && stat_q != '1)
            stat_d = stat_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stat_q <= '0;
        else     stat_q <= stat_d;
    end

    assign stat_conflicts = stat_q;
`endif

endmodule

// File: tb/tb_xregf_arb.sv
// Directed bench for xregf_arb: vector table plus burst, reset and alternation sequences.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef REGF_ADDR_W
`define REGF_ADDR_W 4
`endif

module tb_xregf_arb;

    localparam int AW = `REGF_ADDR_W;
    localparam int DW = `DATA_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we, h_req, h_we;
    logic [AW-1:0] c_addr, h_addr;
    logic [DW-1:0] c_wdata, h_wdata;
    logic [DW-1:0] rd_q;
    logic [DW-1:0] mem [16];

    logic          c_gnt, c_rvalid, h_gnt, h_rvalid, m_sel, m_we;
    logic [DW-1:0] c_rdata, h_rdata, m_wdata;
    logic [AW-1:0] m_addr;

    logic          c_gnt1, c_rvalid1, h_gnt1, h_rvalid1, m_sel1, m_we1;
    logic [DW-1:0] c_rdata1, h_rdata1, m_wdata1;
    logic [AW-1:0] m_addr1;

`ifdef XREGF_ARB_STATS_EN
    logic          stat_clr;
    logic [DW-1:0] stat0, stat1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    xregf_arb #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_sel(m_sel), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(rd_q)
`ifdef XREGF_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_conflicts(stat0)
`endif
    );

    xregf_arb #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt1), .c_rvalid(c_rvalid1), .c_rdata(c_rdata1),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt1), .h_rvalid(h_rvalid1), .h_rdata(h_rdata1),
        .m_sel(m_sel1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_rdata(rd_q)
`ifdef XREGF_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_conflicts(stat1)
`endif
    );

    // Register file model: synchronous write, read data one cycle after select
    always @(posedge clk) begin
        if (m_sel && m_we) mem[m_addr] <= m_wdata;
        rd_q <= mem[m_addr];
    end

    typedef struct {
        logic          cr, cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          hr, hw;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        logic          ecg, ehg, emwe;
        logic [AW-1:0] ema;
        logic [DW-1:0] emd;
        logic          ecrv, ehrv;
        logic [DW-1:0] ecrd, ehrd;
    } vec_t;

    vec_t vt [17];

    function automatic vec_t mk(
        input logic cr, cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
        input logic hr, hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
        input logic ecg, ehg, emwe, input logic [AW-1:0] ema,
        input logic [DW-1:0] emd, input logic ecrv, ehrv,
        input logic [DW-1:0] ecrd, ehrd);
        vec_t v;
        v.cr = cr;   v.cw = cw;   v.ca = ca;   v.cd = cd;
        v.hr = hr;   v.hw = hw;   v.ha = ha;   v.hd = hd;
        v.ecg = ecg; v.ehg = ehg; v.emwe = emwe;
        v.ema = ema; v.emd = emd;
        v.ecrv = ecrv; v.ehrv = ehrv;
        v.ecrd = ecrd; v.ehrd = ehrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] bundle();
        return {c_gnt, h_gnt, m_sel, m_we, m_addr, m_wdata,
                c_rvalid, h_rvalid, c_rdata, h_rdata};
    endfunction

    task automatic drive(input logic cr, cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input logic hr, hw,
                         input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] exp_rd;
        logic [AW-1:0] a;
        logic [1:0]    pat1;

        vt[0]  = mk(1,1,2,32'h5A, 0,0,0,0,     1,0,1,2,32'h5A, 0,0,0,0);
        vt[1]  = mk(1,0,2,0,      0,0,0,0,     1,0,0,2,0,      0,0,0,0);
        vt[2]  = mk(0,0,0,0,      0,0,0,0,     0,0,0,0,0,      1,0,32'h5A,0);
        vt[3]  = mk(0,0,0,0,      1,0,2,0,     0,1,0,2,0,      0,0,32'h5A,0);
        vt[4]  = mk(0,0,0,0,      1,1,3,32'h77,0,1,1,3,32'h77, 0,1,32'h5A,32'h5A);
        vt[5]  = mk(0,0,0,0,      0,0,0,0,     0,0,0,0,0,      0,0,32'h5A,32'h5A);
        vt[6]  = mk(1,0,3,0,      1,0,2,0,     1,0,0,3,0,      0,0,32'h5A,32'h5A);
        vt[7]  = mk(1,0,3,0,      1,0,2,0,     1,0,0,3,0,      1,0,32'h77,32'h5A);
        vt[8]  = mk(1,0,3,0,      1,0,2,0,     1,0,0,3,0,      1,0,32'h77,32'h5A);
        vt[9]  = mk(1,0,3,0,      1,0,2,0,     1,0,0,3,0,      1,0,32'h77,32'h5A);
        vt[10] = mk(1,0,3,0,      1,0,2,0,     0,1,0,2,0,      1,0,32'h77,32'h5A);
        vt[11] = mk(1,0,3,0,      1,0,2,0,     0,1,0,2,0,      0,1,32'h77,32'h5A);
        vt[12] = mk(0,0,0,0,      0,0,0,0,     0,0,0,0,0,      0,1,32'h77,32'h5A);
        vt[13] = mk(1,0,2,0,      0,0,0,0,     1,0,0,2,0,      0,0,32'h77,32'h5A);
        vt[14] = mk(1,1,2,32'hA5, 0,0,0,0,     1,0,1,2,32'hA5, 1,0,32'h5A,32'h5A);
        vt[15] = mk(1,0,2,0,      0,0,0,0,     1,0,0,2,0,      0,0,32'h5A,32'h5A);
        vt[16] = mk(0,0,0,0,      0,0,0,0,     0,0,0,0,0,      1,0,32'hA5,32'h5A);

`ifdef XREGF_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        rst = 1'b1;
        drive(1,0,1,0, 1,0,1,0);
        cyc();
        cyc();
        chk("reset_outputs", bundle(), 128'd0);

        drive(0,0,0,0, 0,0,0,0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            cyc();
            drive(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd,
                  vt[i].hr, vt[i].hw, vt[i].ha, vt[i].hd);
            #2;
            chk($sformatf("vec%0d", i), bundle(),
                {vt[i].ecg, vt[i].ehg, vt[i].ecg | vt[i].ehg, vt[i].emwe,
                 vt[i].ema, vt[i].emd, vt[i].ecrv, vt[i].ehrv,
                 vt[i].ecrd, vt[i].ehrd});
        end

        // Six back-to-back host reads alternating addr 2 (0xA5) and 3 (0x77)
        for (int k = 0; k <= 6; k++) begin
            cyc();
            if (k < 6) begin
                a = AW'(2 + (k % 2));
                drive(0,0,0,0, 1,0,a,0);
            end else begin
                drive(0,0,0,0, 0,0,0,0);
            end
            #2;
            exp_rd = ((k - 1) % 2 == 0) ? 32'hA5 : 32'h77;
            if (k < 6)
                chk($sformatf("h_b2b_gnt%0d", k), {c_gnt, h_gnt}, 2'b01);
            if (k > 0)
                chk($sformatf("h_b2b_rd%0d", k), {h_rvalid, h_rdata},
                    {1'b1, exp_rd});
        end

        // Reset during the grant cycle of a host read drops its rvalid
        cyc();
        drive(0,0,0,0, 1,0,2,0);
        #2;
        chk("rst_pre_gnt", {c_gnt, h_gnt}, 2'b01);
        rst = 1'b1;
        #1;
        chk("rst_gnt_gated", bundle(), 128'd0);
        cyc();
        chk("rst_no_rvalid", bundle(), 128'd0);
        rst = 1'b0;
        drive(1,0,2,0, 1,0,3,0);
        #2;
        chk("rst_tie_c", {c_gnt, h_gnt, m_addr}, {2'b10, AW'(2)});
        chk("mb1_cyc0", {c_gnt1, h_gnt1}, 2'b10);

        // MAX_BURST=1 instance alternates while both request
        for (int k = 1; k < 6; k++) begin
            cyc();
            #2;
            pat1 = (k % 2 == 1) ? 2'b01 : 2'b10;
            chk($sformatf("mb1_cyc%0d", k), {c_gnt1, h_gnt1}, pat1);
            chk($sformatf("no_dual_gnt%0d", k),
                {c_gnt & h_gnt, c_gnt1 & h_gnt1}, 2'b00);
        end

`ifdef XREGF_ARB_STATS_EN
        cyc();
        drive(0,0,0,0, 0,0,0,0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("stat_reset", stat0, '0);
        drive(1,0,1,0, 1,0,1,0);
        for (int k = 0; k < 10; k++) cyc();
        drive(0,0,0,0, 0,0,0,0);
        chk("stat_ten", stat0, DW'(10));
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        chk("stat_clr", stat0, '0);
`endif

        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
